// File: rtl/cmd_scheduler.sv
// Command scheduler: queues 16-bit commands, issues them one at a time to a
// RemoteComm transmitter and tracks response, timeout and bounded retry.
module cmd_scheduler #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned TIMEOUT   = 500000,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [15:0]            push_cmd,
  input  logic                   abort,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   ovf,
  output logic [15:0]            cmd,
  output logic                   snd_cmd,
  input  logic                   cmd_snt,
  input  logic                   resp_rdy,
  input  logic [7:0]             resp,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   err_tmo,
  output logic [7:0]             err_resp
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;
  localparam int unsigned RW = $clog2(MAX_RETRY + 1) + 1;

  typedef enum logic [1:0] {StIdle, StLoad, StWaitSnt, StWaitResp} state_e;

  state_e          state_q, state_d;
  logic [15:0]     mem_q [DEPTH];
  logic [CW-1:0]   wr_ptr_q, rd_ptr_q;
  logic            ovf_q;
  logic [15:0]     cmd_q, cmd_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic            done_q, done_d, err_q, err_d;
  logic            err_tmo_q, err_tmo_d;
  logic [7:0]      err_resp_q, err_resp_d;
  logic            push_ok, pop, snd, timed_out;

  assign count   = wr_ptr_q - rd_ptr_q;
  assign full    = (count == CW'(DEPTH));
  // Fullness is judged before any same-cycle pop.
  assign push_ok = push && !full && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else if (abort) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + CW'(1);
      if (push && full) ovf_q <= 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_cmd;
  end

  assign timed_out = (state_q == StWaitSnt || state_q == StWaitResp) &&
                     (tmo_cnt_q == TW'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    tmo_cnt_d  = tmo_cnt_q;
    retry_d    = retry_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_tmo_d  = err_tmo_q;
    err_resp_d = err_resp_q;
    pop        = 1'b0;
    snd        = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Holding off while done/err is showing spaces commands two cycles apart.
        if (count != '0 && !done_q && !err_q) begin
          state_d   = StLoad;
          pop       = 1'b1;
          cmd_d     = mem_q[rd_ptr_q[AW-1:0]];
          retry_d   = '0;
          tmo_cnt_d = '0;
        end
      end
      StLoad: begin
        snd     = 1'b1;
        state_d = StWaitSnt;
      end
      StWaitSnt, StWaitResp: begin
        tmo_cnt_d = tmo_cnt_q + TW'(1);
        if (state_q == StWaitSnt && cmd_snt) state_d = StWaitResp;
        if (resp_rdy) begin
          state_d = StIdle;
          if (resp == 8'hA5) begin
            done_d = 1'b1;
          end else begin
            err_d      = 1'b1;
            err_tmo_d  = 1'b0;
            err_resp_d = resp;
          end
        end else if (timed_out) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d   = retry_q + RW'(1);
            tmo_cnt_d = '0;
            snd       = 1'b1;
            state_d   = StWaitSnt;
          end else begin
            err_d     = 1'b1;
            err_tmo_d = 1'b1;
            state_d   = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (abort) begin
      state_d    = StIdle;
      cmd_d      = cmd_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      err_tmo_d  = err_tmo_q;
      err_resp_d = err_resp_q;
      pop        = 1'b0;
      snd        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cmd_q      <= '0;
      tmo_cnt_q  <= '0;
      retry_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_tmo_q  <= 1'b0;
      err_resp_q <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      tmo_cnt_q  <= tmo_cnt_d;
      retry_q    <= retry_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_tmo_q  <= err_tmo_d;
      err_resp_q <= err_resp_d;
    end
  end

  assign ovf      = ovf_q;
  assign cmd      = cmd_q;
  assign snd_cmd  = snd;
  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign err      = err_q;
  assign err_tmo  = err_tmo_q;
  assign err_resp = err_resp_q;
endmodule

// File: tb/tb_cmd_scheduler.sv
// Self-checking bench for cmd_scheduler: table-driven single transactions,
// directed corner sequences, and randomized bursts against a queue model.
module tb_cmd_scheduler;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned TIMEOUT   = 100;
  localparam int unsigned MAX_RETRY = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        push = 1'b0;
  logic [15:0] push_cmd = '0;
  logic        abort = 1'b0;
  logic        cmd_snt = 1'b0;
  logic        resp_rdy = 1'b0;
  logic [7:0]  resp = '0;
  logic        full, ovf, snd_cmd, busy, done, err, err_tmo;
  logic [2:0]  count;
  logic [15:0] cmd;
  logic [7:0]  err_resp;

  cmd_scheduler #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .push_cmd(push_cmd), .abort(abort),
    .full(full), .count(count), .ovf(ovf), .cmd(cmd), .snd_cmd(snd_cmd),
    .cmd_snt(cmd_snt), .resp_rdy(resp_rdy), .resp(resp), .busy(busy),
    .done(done), .err(err), .err_tmo(err_tmo), .err_resp(err_resp)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_done = 0;
  int n_err = 0;
  int last_done_cyc = 0;
  logic [15:0] snd_log[$];
  int          snd_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin
      n_done++;
      last_done_cyc = cyc;
    end
    if (err) n_err++;
    if (snd_cmd) begin
      snd_log.push_back(cmd);
      snd_cyc.push_back(cyc);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_snt();
    cmd_snt = 1'b1;
    tick();
    cmd_snt = 1'b0;
  endtask

  task automatic answer(input logic [7:0] r);
    resp     = r;
    resp_rdy = 1'b1;
    tick();
    resp_rdy = 1'b0;
  endtask

  task automatic wait_snd(input string name, input int target, input int budget);
    for (int i = 0; i < budget && snd_log.size() < target; i++) tick();
    check(name, 32'(snd_log.size() >= target), 1);
  endtask

  task automatic wait_outcome(input string name, input int d0, input int e0, input int budget);
    for (int i = 0; i < budget && n_done == d0 && n_err == e0; i++) tick();
    check(name, 32'(n_done != d0 || n_err != e0), 1);
  endtask

  typedef struct {
    logic [15:0] c;
    logic [7:0]  r;
    logic        exp_done;
    logic        exp_err;
    logic [7:0]  exp_err_resp;
  } vec_t;

  vec_t vecs[6];
  logic [15:0] exp_cmd_q[$];
  logic [7:0]  exp_rsp_q[$];

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, d0, e0, k;
    logic [15:0] c;
    logic [7:0]  r;

    // Reset state
    #3;
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_cmd", cmd, 0);
    check("rst_err_resp", err_resp, 0);
    check("rst_flags", {ovf, snd_cmd, done, err, err_tmo}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();

    vecs[0] = '{16'h0000, 8'hA5, 1'b1, 1'b0, 8'h00};
    vecs[1] = '{16'h2345, 8'h5A, 1'b0, 1'b1, 8'h5A};
    vecs[2] = '{16'hFFFF, 8'hA5, 1'b1, 1'b0, 8'h5A};
    vecs[3] = '{16'h8001, 8'h00, 1'b0, 1'b1, 8'h00};
    vecs[4] = '{16'h1234, 8'hA4, 1'b0, 1'b1, 8'hA4};
    vecs[5] = '{16'hABCD, 8'hA5, 1'b1, 1'b0, 8'hA4};

    foreach (vecs[i]) begin
      s0 = snd_log.size(); d0 = n_done; e0 = n_err;
      push_cmd = vecs[i].c; push = 1'b1; tick(); push = 1'b0;
      wait_snd("vec_snd", s0 + 1, 20);
      check("vec_cmd", cmd, vecs[i].c);
      tick(); pulse_snt(); tick();
      answer(vecs[i].r);
      wait_outcome("vec_outcome", d0, e0, 10);
      repeat (4) tick();
      check("vec_done", n_done - d0, vecs[i].exp_done);
      check("vec_err", n_err - e0, vecs[i].exp_err);
      check("vec_err_resp", err_resp, vecs[i].exp_err_resp);
      if (vecs[i].exp_err) check("vec_err_tmo", err_tmo, 0);
      check("vec_nsnd", snd_log.size() - s0, 1);
      check("vec_idle", {busy, count}, 0);
    end

    // Timeout with retries, never answered
    s0 = snd_log.size(); d0 = n_done; e0 = n_err;
    push_cmd = 16'h7777; push = 1'b1; tick(); push = 1'b0;
    for (int i = 0; i < 400 && n_err == e0; i++) tick();
    tick();
    check("tmo_nsnd", snd_log.size() - s0, 3);
    if (snd_log.size() - s0 >= 3) begin
      check("tmo_gap1", snd_cyc[s0 + 1] - snd_cyc[s0], TIMEOUT);
      check("tmo_gap2", snd_cyc[s0 + 2] - snd_cyc[s0 + 1], TIMEOUT);
      check("tmo_cmd", snd_log[s0 + 2], 16'h7777);
    end
    check("tmo_err", n_err - e0, 1);
    check("tmo_err_tmo", err_tmo, 1);
    check("tmo_done", n_done - d0, 0);
    check("tmo_busy", busy, 0);

    // Overflow while the first command is stalled
    s0 = snd_log.size(); d0 = n_done;
    push_cmd = 16'h1000; push = 1'b1; tick(); push = 1'b0;
    wait_snd("ovf_snd0", s0 + 1, 20);
    pulse_snt();
    for (int i = 1; i <= 5; i++) begin
      push_cmd = 16'h1000 + 16'(i); push = 1'b1; tick();
    end
    push = 1'b0;
    check("ovf_full", full, 1);
    check("ovf_count", count, DEPTH);
    check("ovf_flag", ovf, 1);
    for (int i = 0; i < 5; i++) begin
      wait_snd("ovf_snd", s0 + i + 1, 20);
      if (i > 0) check("ovf_gap", 32'(snd_cyc[s0 + i] - last_done_cyc >= 2), 1);
      check("ovf_order", cmd, 16'h1000 + 16'(i));
      if (i > 0) pulse_snt();
      tick();
      c = 16'(n_done);
      answer(8'hA5);
      wait_outcome("ovf_outcome", int'(c), n_err, 10);
    end
    repeat (4) tick();
    check("ovf_ndone", n_done - d0, 5);
    check("ovf_nsnd", snd_log.size() - s0, 5);
    check("ovf_sticky", ovf, 1);
    abort = 1'b1; tick(); abort = 1'b0;
    check("ovf_cleared", ovf, 0);

    // Abort in WAIT_RESP with two queued, colliding with a response
    s0 = snd_log.size(); d0 = n_done; e0 = n_err;
    for (int i = 0; i < 3; i++) begin
      push_cmd = 16'hB000 + 16'(i); push = 1'b1; tick();
    end
    push = 1'b0;
    wait_snd("abt_snd", s0 + 1, 20);
    pulse_snt();
    check("abt_count_pre", count, 2);
    abort = 1'b1; resp_rdy = 1'b1; resp = 8'hA5; tick();
    abort = 1'b0; resp_rdy = 1'b0;
    check("abt_count", count, 0);
    check("abt_busy", busy, 0);
    tick(); answer(8'hA5);
    repeat (5) tick();
    check("abt_done", n_done - d0, 0);
    check("abt_err", n_err - e0, 0);
    check("abt_nsnd", snd_log.size() - s0, 1);

    // Asynchronous reset during WAIT_SNT
    s0 = snd_log.size(); d0 = n_done; e0 = n_err;
    push_cmd = 16'hC001; push = 1'b1; tick();
    push_cmd = 16'hC002; tick(); push = 1'b0;
    wait_snd("ars_snd", s0 + 1, 20);
    push_cmd = 16'hC003; push = 1'b1; tick(); push = 1'b0;
    check("ars_pre_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("ars_busy", busy, 0);
    check("ars_count", count, 0);
    check("ars_cmd", cmd, 0);
    check("ars_err_resp", err_resp, 0);
    check("ars_flags", {full, ovf, snd_cmd, done, err, err_tmo}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(); pulse_snt(); answer(8'hA5);
    repeat (5) tick();
    check("ars_done", n_done - d0, 0);
    check("ars_nsnd", snd_log.size() - s0, 1);
    check("ars_idle", {busy, count}, 0);

    // Randomized bursts against a queue-order/outcome model
    for (int b = 0; b < 20; b++) begin
      k = $urandom_range(1, DEPTH);
      s0 = snd_log.size();
      for (int i = 0; i < k; i++) begin
        c = 16'($urandom);
        r = ($urandom_range(0, 1) == 0) ? 8'hA5 : 8'($urandom);
        exp_cmd_q.push_back(c);
        exp_rsp_q.push_back(r);
        push_cmd = c; push = 1'b1; tick();
      end
      push = 1'b0;
      for (int i = 0; i < k; i++) begin
        c = exp_cmd_q.pop_front();
        r = exp_rsp_q.pop_front();
        d0 = n_done; e0 = n_err;
        wait_snd("rnd_snd", s0 + i + 1, 30);
        check("rnd_cmd", cmd, c);
        repeat ($urandom_range(0, 3)) tick();
        if ($urandom_range(0, 3) != 0) pulse_snt();
        repeat ($urandom_range(0, 3)) tick();
        answer(r);
        wait_outcome("rnd_outcome", d0, e0, 10);
        check("rnd_kind", {n_done - d0 == 1, n_err - e0 == 1}, (r == 8'hA5) ? 2'b10 : 2'b01);
        if (r != 8'hA5) check("rnd_err_resp", {err_tmo, err_resp}, {1'b0, r});
      end
      repeat (4) tick();
      check("rnd_idle", {busy, count, ovf}, 0);
      check("rnd_nsnd", snd_log.size() - s0, k);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cmd_scheduler.md
CMD_SCHEDULER -- requirements
Module: cmd_scheduler

Interface
REQ-001 Parameter DEPTH, default 4: command FIFO entries; power of 2.
REQ-002 Parameter TIMEOUT, default 500000: cycles allowed from snd_cmd pulse to resp_rdy.
REQ-003 Parameter MAX_RETRY, default 2: resends after timeout before an error is reported.
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  reset; asynchronous and active-low.
REQ-006 push  in  1  enqueue push_cmd this cycle.
REQ-007 push_cmd  in  16  command word to enqueue.
REQ-008 abort  in  1  flush FIFO and drop the outstanding command.
REQ-009 full  out  1  FIFO holds DEPTH entries.
REQ-010 count  out  $clog2(DEPTH)+1  FIFO occupancy.
REQ-011 ovf  out  1  sticky: push was dropped because FIFO was full.
REQ-012 cmd  out  16  command word presented to the RemoteComm transmitter.
REQ-013 snd_cmd  out  1  one-cycle pulse starting transmission of cmd.
REQ-014 cmd_snt  in  1  transmitter finished sending cmd.
REQ-015 resp_rdy  in  1  response byte valid.
REQ-016 resp  in  8  response byte.
REQ-017 busy  out  1  a command is outstanding (state other than IDLE).
REQ-018 done  out  1  one-cycle pulse: outstanding command acknowledged with 8'hA5.
REQ-019 err  out  1  one-cycle pulse: outstanding command failed.
REQ-020 err_tmo  out  1  qualifies err: 1 = retries exhausted, 0 = bad response; held until the next err.
REQ-021 err_resp  out  8  last non-A5 response byte; held until the next bad response.

Function
REQ-022 FIFO: push accepted when !full; full is evaluated before any same-cycle pop; a push while full is dropped and sets ovf.
REQ-023 States IDLE, LOAD, WAIT_SNT, WAIT_RESP.
REQ-024 IDLE -> LOAD when count>0; LOAD pops the head into cmd, clears the retry count and the timeout counter.
REQ-025 LOAD -> WAIT_SNT unconditionally; snd_cmd is high for exactly the LOAD cycle, and cmd is stable from LOAD until the state returns to IDLE.
REQ-026 WAIT_SNT -> WAIT_RESP on cmd_snt; a resp_rdy in WAIT_SNT is treated as occurring in WAIT_RESP.
REQ-027 The timeout counter increments every cycle in WAIT_SNT and WAIT_RESP; it times out on reaching TIMEOUT-1.
REQ-028 resp_rdy with resp==8'hA5 -> done pulse next cycle, then IDLE.
REQ-029 resp_rdy with any other resp -> err pulse with err_tmo=0 and err_resp=resp, then IDLE; the command is not retried.
REQ-030 On timeout with retry count < MAX_RETRY: increment the retry count, clear the counter, re-pulse snd_cmd with the same cmd, and go to WAIT_SNT.
REQ-031 On timeout with retry count == MAX_RETRY: err pulse with err_tmo=1, then IDLE.
REQ-032 resp_rdy and timeout in the same cycle: resp_rdy wins.
REQ-033 abort in any state: FIFO emptied (count=0), state -> IDLE, no done/err pulse, ovf cleared; abort has priority over push, resp_rdy and timeout in the same cycle.
REQ-034 resp_rdy or cmd_snt received in IDLE is ignored.
REQ-035 busy = (state != IDLE); done and err are never high in the same cycle.
REQ-036 Back-to-back: after done or err, the next queued command reaches LOAD no earlier than 2 cycles later.

Reset
REQ-037 While rst_n is low: state=IDLE, FIFO empty, count=0, full=0, ovf=0, cmd=16'h0000, snd_cmd=0, busy=0, done=0, err=0, err_tmo=0, err_resp=8'h00, all counters 0.
REQ-038 Reset asserted mid-transaction discards the outstanding command and all queued commands; a response arriving after reset release is ignored per REQ-034.

Verification
REQ-039 Push 16'h0000 -> snd_cmd pulses once with cmd=16'h0000; cmd_snt, then resp_rdy with 8'hA5 -> exactly one done pulse, busy=0, count=0.
REQ-040 Push 16'h2345 and answer with resp=8'h5A -> err=1, err_tmo=0, err_resp=8'h5A, no resend, and no done pulse.
REQ-041 TIMEOUT=100, MAX_RETRY=2, never answer -> snd_cmd pulses 3 times at 100-cycle intervals, then err=1 with err_tmo=1, busy=0.
REQ-042 DEPTH=4 while the first command is stalled in WAIT_RESP: push 5 more -> full=1, count=4, ovf=1, and the 5th is lost; answer every command with A5 -> 5 done pulses in push order.
REQ-043 abort during WAIT_RESP with 2 commands queued -> count=0, busy=0, no done/err; a following resp_rdy with A5 produces no done.
REQ-044 rst_n pulsed low asynchronously during WAIT_SNT -> all outputs reach their REQ-037 values without waiting for a clock edge; late cmd_snt/resp_rdy are ignored.
